// File: rtl/gnn_frame_loader.sv
// Loads one 40-word frame from a valid/ready stream into the parallel feature/weight buses of the
// 4-node GNN core, strikes in_ready once, then holds the buses until the core reports completion.
module gnn_frame_loader #(
  parameter int DW    = 5,
  parameter int NFEAT = 16,
  parameter int NWGT  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [NFEAT*DW-1:0]   feat_o,
  output logic [NWGT*DW-1:0]    wgt_o,
  output logic                  in_ready,
  input  logic                  res_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt,
  output logic [1:0]            dbg_state_o
);

  localparam int NW = NFEAT + NWGT;
  localparam logic [5:0] CNT_LAST = 6'(NW - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_FIRE  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Stream handshake: a word moves on a cycle where s_valid and s_ready are both high at the
  // rising edge; s_ready is a registered copy of "next state accepts words".
  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [NW*DW-1:0]   words_q, words_d;
  logic               s_ready_q, s_ready_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               beat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    beat        = s_valid & s_ready_q;
    case (state_q)
      S_LOAD: begin
        if (beat) begin
          words_d[DW*int'(cnt_q) +: DW] = s_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d = 6'd0;
            if (s_last) begin
              state_d = S_FIRE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_DRAIN;
            end
          end else if (s_last) begin
            // Short frame: partial words stay on the buses until overwritten.
            frame_err_d = 1'b1;
            cnt_d       = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (beat && s_last) begin
          state_d = S_LOAD;
          cnt_d   = 6'd0;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_done) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          cnt_d       = 6'd0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Outputs are registered from the next state so they line up with it.
    s_ready_d  = (state_d == S_LOAD) || (state_d == S_DRAIN);
    in_ready_d = (state_d == S_FIRE);
    busy_d     = (state_d == S_FIRE) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= 6'd0;
      words_q     <= '0;
      s_ready_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      s_ready_q   <= s_ready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign feat_o      = words_q[NFEAT*DW-1:0];
  assign wgt_o       = words_q[NW*DW-1:NFEAT*DW];
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule
